// File: rtl/fp_mantissa_align_add_pkg.sv
// Shared widths, the aligned-add result payload and float32 special constants.
// Contents: EXP_W/FRAC_W widths, align_result_t register payload,
//           pos_inf_32 / neg_inf_32 / nan_exp_32 for the enclosing float adder.
package fp_mantissa_align_add_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;

  // Float32 special encodings used by the surrounding adder.
  localparam logic [31:0]      pos_inf_32 = 32'h7F80_0000;
  localparam logic [31:0]      neg_inf_32 = 32'hFF80_0000;
  localparam logic [EXP_W-1:0] nan_exp_32 = 8'hFF;

  // One registered result of the align-and-add stage.
  typedef struct packed {
    logic [EXP_W-1:0]  diff;
    logic              borrow;
    logic [EXP_W-1:0]  exp_max;
    logic [FRAC_W-1:0] frac_shifted;
    logic [FRAC_W-1:0] sum;
    logic              cout;
  } align_result_t;

endpackage

// File: rtl/fp_mantissa_align_add_csa.sv
// 23-bit combinational carry-select adder: {cout, sum} = a + b.
// Ports: a, b (23-bit addends), sum (low 23 bits), cout (carry out).
// Structure: 7-bit ripple low block, then four 4-bit select blocks that
// precompute both carry-in cases and pick one with the incoming carry.
module carry_select_adder_23
  import fp_mantissa_align_add_pkg::*;
(
  input  logic [FRAC_W-1:0] a,
  input  logic [FRAC_W-1:0] b,
  output logic [FRAC_W-1:0] sum,
  output logic              cout
);

  localparam int unsigned LOW_W = 7;
  localparam int unsigned BLK_W = 4;
  localparam int unsigned NBLK  = (FRAC_W - LOW_W) / BLK_W;

  logic [NBLK:0]  carry;
  logic [LOW_W:0] low;

  // Low ripple block.
  assign low              = {1'b0, a[LOW_W-1:0]} + {1'b0, b[LOW_W-1:0]};
  assign sum[LOW_W-1:0]   = low[LOW_W-1:0];
  assign carry[0]         = low[LOW_W];

  // Select blocks: both carry-in results computed, incoming carry picks one.
  for (genvar g = 0; g < int'(NBLK); g++) begin : g_blk
    localparam int unsigned LSB = LOW_W + BLK_W * 32'(g);
    logic [BLK_W:0] s0;
    logic [BLK_W:0] s1;
    assign s0 = {1'b0, a[LSB +: BLK_W]} + {1'b0, b[LSB +: BLK_W]};
    assign s1 = {1'b0, a[LSB +: BLK_W]} + {1'b0, b[LSB +: BLK_W]} + (BLK_W+1)'(1);
    assign sum[LSB +: BLK_W] = carry[g] ? s1[BLK_W-1:0] : s0[BLK_W-1:0];
    assign carry[g+1]        = carry[g] ? s1[BLK_W]     : s0[BLK_W];
  end

  assign cout = carry[NBLK];

endmodule

// File: rtl/fp_mantissa_align_add.sv
// Registered exponent-subtract, fraction-align and fraction-add stage.
// Inputs : clk, rst_n (async active-low), in_valid, exp_a, exp_b, frac_a, frac_b.
// Outputs: out_valid, diff (exp_a-exp_b mod 256), borrow (exp_b>exp_a),
//          exp_max, frac_shifted (aligned smaller-exponent fraction),
//          sum/cout (kept fraction + aligned fraction). Latency 1, no backpressure.
module fp_mantissa_align_add
  import fp_mantissa_align_add_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [EXP_W-1:0]  exp_a,
  input  logic [EXP_W-1:0]  exp_b,
  input  logic [FRAC_W-1:0] frac_a,
  input  logic [FRAC_W-1:0] frac_b,
  output logic              out_valid,
  output logic [EXP_W-1:0]  diff,
  output logic              borrow,
  output logic [EXP_W-1:0]  exp_max,
  output logic [FRAC_W-1:0] frac_shifted,
  output logic [FRAC_W-1:0] sum,
  output logic              cout
);

  logic [EXP_W:0]    sub_c;
  logic              borrow_c;
  logic [EXP_W-1:0]  shamt_c;
  logic [FRAC_W-1:0] shift_src_c;
  logic [FRAC_W-1:0] keep_c;
  logic [FRAC_W-1:0] shifted_c;
  logic [FRAC_W-1:0] sum_c;
  logic              cout_c;
  align_result_t     res_c;
  align_result_t     res_q;
  logic              valid_q;

  // 9-bit exponent subtract; MSB is the borrow.
  assign sub_c    = {1'b0, exp_a} - {1'b0, exp_b};
  assign borrow_c = sub_c[EXP_W];

  // Absolute exponent difference and operand selection.
  assign shamt_c     = borrow_c ? EXP_W'(~sub_c[EXP_W-1:0] + EXP_W'(1)) : sub_c[EXP_W-1:0];
  assign shift_src_c = borrow_c ? frac_a : frac_b;
  assign keep_c      = borrow_c ? frac_b : frac_a;

  // Log barrel shifter (1,2,4,8,16); anything at or beyond the width clears.
  always_comb begin
    shifted_c = shift_src_c;
    if (shamt_c[0]) shifted_c = shifted_c >> 1;
    if (shamt_c[1]) shifted_c = shifted_c >> 2;
    if (shamt_c[2]) shifted_c = shifted_c >> 4;
    if (shamt_c[3]) shifted_c = shifted_c >> 8;
    if (shamt_c[4]) shifted_c = shifted_c >> 16;
    if (shamt_c >= EXP_W'(FRAC_W)) shifted_c = '0;
  end

  carry_select_adder_23 u_csa (
    .a    (keep_c),
    .b    (shifted_c),
    .sum  (sum_c),
    .cout (cout_c)
  );

  always_comb begin
    res_c              = '0;
    res_c.diff         = sub_c[EXP_W-1:0];
    res_c.borrow       = borrow_c;
    res_c.exp_max      = borrow_c ? exp_b : exp_a;
    res_c.frac_shifted = shifted_c;
    res_c.sum          = sum_c;
    res_c.cout         = cout_c;
  end

  // Data loads only on valid input; valid tracks the input one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) res_q <= res_c;
    end
  end

  assign out_valid    = valid_q;
  assign diff         = res_q.diff;
  assign borrow       = res_q.borrow;
  assign exp_max      = res_q.exp_max;
  assign frac_shifted = res_q.frac_shifted;
  assign sum          = res_q.sum;
  assign cout         = res_q.cout;

endmodule

// File: tb/tb_fp_mantissa_align_add.sv
// Directed self-checking bench for fp_mantissa_align_add.
// Observed outputs are packed as {out_valid, diff, borrow, exp_max,
// frac_shifted, sum, cout} (65 bits) and compared to hand-computed values.
module tb_fp_mantissa_align_add;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  exp_a;
  logic [7:0]  exp_b;
  logic [22:0] frac_a;
  logic [22:0] frac_b;
  logic        out_valid;
  logic [7:0]  diff;
  logic        borrow;
  logic [7:0]  exp_max;
  logic [22:0] frac_shifted;
  logic [22:0] sum;
  logic        cout;

  logic [64:0] obs;
  int          n_vec;
  int          n_bad;

  typedef struct packed {
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [22:0] fa;
    logic [22:0] fb;
    logic [64:0] res;
  } vec_t;

  fp_mantissa_align_add dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .exp_a        (exp_a),
    .exp_b        (exp_b),
    .frac_a       (frac_a),
    .frac_b       (frac_b),
    .out_valid    (out_valid),
    .diff         (diff),
    .borrow       (borrow),
    .exp_max      (exp_max),
    .frac_shifted (frac_shifted),
    .sum          (sum),
    .cout         (cout)
  );

  assign obs = {out_valid, diff, borrow, exp_max, frac_shifted, sum, cout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [64:0] pk(input logic v, input logic [7:0] d, input logic b,
                                     input logic [7:0] m, input logic [22:0] sh,
                                     input logic [22:0] s, input logic c);
    return {v, d, b, m, sh, s, c};
  endfunction

  task automatic drive(input logic [7:0] ea, input logic [7:0] eb,
                       input logic [22:0] fa, input logic [22:0] fb);
    in_valid = 1'b1;
    exp_a    = ea;
    exp_b    = eb;
    frac_a   = fa;
    frac_b   = fb;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_a    = 8'h00;
    exp_b    = 8'h00;
    frac_a   = 23'h0;
    frac_b   = 23'h0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (obs !== 65'h0) begin
      n_bad++;
      $display("FAIL reset_state: got %h want %h", obs, 65'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single vectors, one result checked one edge after each input.
  task automatic test_align_add();
    vec_t v [9];
    v[0] = '{8'h85, 8'h82, 23'h400000, 23'h200000, pk(1, 8'h03, 0, 8'h85, 23'h040000, 23'h440000, 0)};
    v[1] = '{8'h10, 8'h14, 23'h7FFFFF, 23'h000001, pk(1, 8'hFC, 1, 8'h14, 23'h07FFFF, 23'h080000, 0)};
    v[2] = '{8'h7F, 8'h7F, 23'h7FFFFF, 23'h000001, pk(1, 8'h00, 0, 8'h7F, 23'h000001, 23'h000000, 1)};
    v[3] = '{8'hFE, 8'h01, 23'h123456, 23'h7FFFFF, pk(1, 8'hFD, 0, 8'hFE, 23'h000000, 23'h123456, 0)};
    v[4] = '{8'h96, 8'h80, 23'h000010, 23'h7FFFFF, pk(1, 8'h16, 0, 8'h96, 23'h000001, 23'h000011, 0)};
    v[5] = '{8'h97, 8'h80, 23'h000010, 23'h7FFFFF, pk(1, 8'h17, 0, 8'h97, 23'h000000, 23'h000010, 0)};
    v[6] = '{8'h80, 8'h96, 23'h7FFFFF, 23'h7FFFFF, pk(1, 8'hEA, 1, 8'h96, 23'h000001, 23'h000000, 1)};
    v[7] = '{8'h80, 8'h97, 23'h7FFFFF, 23'h000005, pk(1, 8'hE9, 1, 8'h97, 23'h000000, 23'h000005, 0)};
    v[8] = '{8'h00, 8'hFF, 23'h400000, 23'h400000, pk(1, 8'h01, 1, 8'hFF, 23'h000000, 23'h400000, 0)};
    for (int i = 0; i < 9; i++) begin
      drive(v[i].ea, v[i].eb, v[i].fa, v[i].fb);
      @(posedge clk);
      #1;
      n_vec++;
      if (obs !== v[i].res) begin
        n_bad++;
        $display("FAIL align_add[%0d]: got %h want %h", i, obs, v[i].res);
      end
    end
  endtask

  // Four valid cycles in a row, then an idle gap where data must hold.
  task automatic test_back_to_back();
    vec_t v [4];
    logic [64:0] hold;
    v[0] = '{8'h01, 8'h01, 23'h000003, 23'h000004, pk(1, 8'h00, 0, 8'h01, 23'h000004, 23'h000007, 0)};
    v[1] = '{8'h05, 8'h03, 23'h400000, 23'h400000, pk(1, 8'h02, 0, 8'h05, 23'h100000, 23'h500000, 0)};
    v[2] = '{8'h03, 8'h05, 23'h400000, 23'h400000, pk(1, 8'hFE, 1, 8'h05, 23'h100000, 23'h500000, 0)};
    v[3] = '{8'h20, 8'h00, 23'h7FFFFF, 23'h7FFFFF, pk(1, 8'h20, 0, 8'h20, 23'h000000, 23'h7FFFFF, 0)};
    for (int i = 0; i < 4; i++) begin
      drive(v[i].ea, v[i].eb, v[i].fa, v[i].fb);
      @(posedge clk);
      #1;
      n_vec++;
      if (obs !== v[i].res) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got %h want %h", i, obs, v[i].res);
      end
    end
    hold = {1'b0, v[3].res[63:0]};
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b0;
      exp_a    = 8'h3C + 8'(i);
      exp_b    = 8'h11;
      frac_a   = 23'h0ABCDE;
      frac_b   = 23'h555555;
      @(posedge clk);
      #1;
      n_vec++;
      if (obs !== hold) begin
        n_bad++;
        $display("FAIL gap_hold[%0d]: got %h want %h", i, obs, hold);
      end
    end
  endtask

  // Async reset between edges clears outputs at once; one edge to recover.
  task automatic test_async_reset();
    logic [64:0] want;
    drive(8'h85, 8'h82, 23'h400000, 23'h200000);
    @(posedge clk);
    #1;
    want = pk(1, 8'h03, 0, 8'h85, 23'h040000, 23'h440000, 0);
    n_vec++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL pre_reset: got %h want %h", obs, want);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs !== 65'h0) begin
      n_bad++;
      $display("FAIL async_reset: got %h want %h", obs, 65'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h10, 8'h14, 23'h7FFFFF, 23'h000001);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    want = pk(1, 8'hFC, 1, 8'h14, 23'h07FFFF, 23'h080000, 0);
    n_vec++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL post_reset: got %h want %h", obs, want);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_align_add();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_mantissa_align_add.md
# fp_mantissa_align_add

Registered mantissa-alignment and add datapath for the Vector ALU single-precision adder. It subtracts the two 8-bit exponents and right-shifts the fraction of the smaller-exponent operand by the exponent difference. It then adds that shifted fraction to the other fraction with a 23-bit carry-select adder. It replaces the combinational exponent-subtract, shift and add chain inside the float adder with a single pipelined stage. Sign, special-value (inf/NaN) handling and normalisation are done by the enclosing float adder, not here.

## Interface
- No parameters; widths are fixed at 8-bit exponent and 23-bit fraction.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  inputs below are valid this cycle.
- exp_a  in  8  exponent field of operand A.
- exp_b  in  8  exponent field of operand B.
- frac_a  in  23  fraction field of operand A.
- frac_b  in  23  fraction field of operand B.
- out_valid  out  1  registered outputs below hold a result.
- diff  out  8  raw exp_a − exp_b, modulo 256.
- borrow  out  1  1 when exp_b > exp_a.
- exp_max  out  8  larger of the two exponents.
- frac_shifted  out  23  aligned (right-shifted) fraction.
- sum  out  23  low 23 bits of the fraction sum.
- cout  out  1  carry out of the fraction sum.

## Operation
- Exponent subtract: {borrow, diff} = {1'b0, exp_a} − {1'b0, exp_b}, 9-bit result.
- Shift amount: diff when borrow=0; otherwise (−diff) mod 256, i.e. exp_b − exp_a. The shift amount is always the absolute exponent difference.
- Operand selection:
  - borrow=0 (exp_a ≥ exp_b, including equal): shift frac_b, keep frac_a, exp_max=exp_a.
  - borrow=1: shift frac_a, keep frac_b, exp_max=exp_b.
- Shifter: logical right shift that fills zeros from the MSB side.
  - Shift amount ≥ 23 gives frac_shifted = 0.
  - Shift amount 0 passes the fraction through unchanged.
  - Shifted-out bits are discarded; there are no guard or sticky bits.
- Adder: {cout, sum} = kept_fraction + frac_shifted, unsigned 24-bit result.
  - Carry-select structure: a ripple low block plus select blocks that each precompute results for carry-in 0 and carry-in 1.
  - Block size is an implementation choice. The result must be bit-exact with plain addition.
- Fractions are the raw 23-bit fields. No hidden bit is inserted.
- No special-value detection: exponent 0xFF and 0x00 are treated as ordinary numbers.

## Timing
- Latency 1: inputs sampled at edge N appear on the outputs after edge N.
- Fully pipelined: one new operand pair is accepted every cycle and there is no backpressure.
- out_valid follows in_valid with a 1-cycle delay.
- Data registers load only when in_valid=1. When in_valid=0 the data outputs hold their previous values and out_valid drops.
- Reset: rst_n low immediately clears every output (out_valid, diff, borrow, exp_max, frac_shifted, sum, cout) to 0, regardless of clk.
- Reset asserted mid-stream: the in-flight result is discarded. The first valid result after rst_n rises appears one edge after its input was sampled.

## Structure
- Shared package constants: EXP_W=8 and FRAC_W=23.
- Also in the package: the float32 special constants pos_inf_32, neg_inf_32 and nan_exp_32, which the enclosing float adder uses.
- One natural sub-module: carry_select_adder_23, a combinational 23-bit carry-select adder with ports a, b, sum and cout.
- The exponent subtractor and the barrel shifter are written inline:
  - Subtractor: 9-bit subtract.
  - Shifter: 5 stages shifting by 1, 2, 4, 8 and 16, plus the ≥23 zeroing.

## Test plan
- exp_a=0x85, exp_b=0x82, frac_a=0x400000, frac_b=0x200000, in_valid=1 → next cycle: diff=0x03, borrow=0, exp_max=0x85, frac_shifted=0x040000, sum=0x440000, cout=0, out_valid=1.
- exp_a=0x10, exp_b=0x14, frac_a=0x7FFFFF, frac_b=0x000001 → diff=0xFC, borrow=1, exp_max=0x14, frac_shifted=0x07FFFF, sum=0x080000, cout=0.
- exp_a=exp_b=0x7F, frac_a=0x7FFFFF, frac_b=0x000001 → diff=0x00, borrow=0, frac_shifted=0x000001, sum=0x000000, cout=1.
- exp_a=0xFE, exp_b=0x01, frac_a=0x123456, frac_b=0x7FFFFF → diff=0xFD, frac_shifted=0, sum=0x123456, cout=0. Repeat with the difference at exactly 22 and 23 to check the shifter boundary.
- Back-to-back valid inputs for 4 cycles, then an in_valid=0 gap → one result per cycle in order; out_valid=0 during the gap while data outputs hold.
- rst_n pulled low asynchronously between edges while results are valid → all outputs 0 immediately. After release, one input → result after one edge.
